// File: rtl/reg_bus_master.sv
// reg_bus_master: register-bus initiator.
// Takes one register-access command at a time over a valid/ready channel,
// issues a single-cycle read or write strobe on the peripheral register bus,
// waits RD_LAT cycles for read data, and returns one response per command.
// Also turns the peripheral overflow level into a one-cycle interrupt pulse
// and a saturating edge count.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/cmd_addr/cmd_wdata  command payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_write/rsp_rdata           response payload (rdata 0 for writes)
//   bus_wr_en/bus_rd_en           one-cycle bus strobes
//   bus_addr/bus_wdata/bus_rdata  bus address and data
//   bus_overflow                  peripheral overflow level
//   ovf_irq/ovf_events            overflow edge pulse and saturating count
module reg_bus_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int EVT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              bus_wr_en,
  output logic              bus_rd_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_overflow,
  output logic              ovf_irq,
  output logic [EVT_W-1:0]  ovf_events
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [2:0]       LAT_INIT = 3'(RD_LAT);
  localparam logic [EVT_W-1:0] EVT_MAX  = '1;
  localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       ovf_prev;
  logic       ovf_rise;

  // Command FSM. The bus address/data registers double as the command latch,
  // and bus_wr_en in ACCESS tells which kind of access is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      bus_wr_en <= 1'b0;
      bus_rd_en <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            bus_wr_en <= cmd_write;
            bus_rd_en <= ~cmd_write;
            bus_addr  <= cmd_addr;
            bus_wdata <= cmd_write ? cmd_wdata : '0;
            state     <= ACCESS;
          end else begin
            // cmd_ready comes up one edge after reset release
            cmd_ready <= 1'b1;
          end
        end
        ACCESS: begin
          bus_wr_en <= 1'b0;
          bus_rd_en <= 1'b0;
          bus_wdata <= '0;
          if (bus_wr_en) begin
            bus_addr  <= '0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // address stays on the bus until the data is captured
          if (lat_cnt == 3'd1) begin
            rsp_rdata <= bus_rdata;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            bus_addr  <= '0;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overflow edge detector, independent of the command FSM.
  assign ovf_rise = bus_overflow & ~ovf_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_prev   <= 1'b0;
      ovf_irq    <= 1'b0;
      ovf_events <= '0;
    end else begin
      ovf_prev <= bus_overflow;
      ovf_irq  <= ovf_rise;
      if (ovf_rise && ovf_events != EVT_MAX)
        ovf_events <= ovf_events + EVT_ONE;
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboard bench for reg_bus_master. Instance a: defaults (RD_LAT=1,
// EVT_W=8), checked by a queue-based monitor. Instance b: RD_LAT=3, EVT_W=2,
// shares clk/rst/bus_overflow and is checked directly.
module tb_reg_bus_master;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic        bus_wr_en, bus_rd_en;
  logic [9:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_overflow, ovf_irq;
  logic [7:0]  ovf_events;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [9:0]  b_cmd_addr;
  logic [31:0] b_cmd_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_write;
  logic [31:0] b_rsp_rdata;
  logic        b_bus_wr_en, b_bus_rd_en;
  logic [9:0]  b_bus_addr;
  logic [31:0] b_bus_wdata, b_bus_rdata;
  logic        b_ovf_irq;
  logic [1:0]  b_ovf_events;

  reg_bus_master u_a (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_overflow(bus_overflow), .ovf_irq(ovf_irq), .ovf_events(ovf_events)
  );

  reg_bus_master #(.RD_LAT(3), .EVT_W(2)) u_b (
    .clk(clk), .rst(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_write(b_rsp_write),
    .rsp_rdata(b_rsp_rdata),
    .bus_wr_en(b_bus_wr_en), .bus_rd_en(b_bus_rd_en), .bus_addr(b_bus_addr),
    .bus_wdata(b_bus_wdata), .bus_rdata(b_bus_rdata),
    .bus_overflow(bus_overflow), .ovf_irq(b_ovf_irq), .ovf_events(b_ovf_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Slave register contents
  function automatic logic [31:0] slave_mem(input logic [9:0] a);
    case (a)
      10'h004: slave_mem = 32'h0000_0003;
      10'h008: slave_mem = 32'h0000_0000;
      10'h00C: slave_mem = 32'hDEAD_BEEF;
      10'h010: slave_mem = 32'h1234_5678;
      default: slave_mem = 32'h0000_0BAD;
    endcase
  endfunction

  // Slaves: data is valid only in the cycle exactly RD_LAT after the strobe,
  // junk otherwise, so a wrong capture cycle is visible.
  int a_cnt = -1, b_cnt = -1;
  logic [31:0] a_val = '0, b_val = '0;
  always @(negedge clk) begin
    if (rst) begin
      a_cnt = -1; b_cnt = -1;
    end else begin
      if (bus_rd_en) begin a_cnt = 0; a_val = slave_mem(bus_addr); end
      else if (a_cnt >= 0) a_cnt++;
      if (b_bus_rd_en) begin b_cnt = 0; b_val = slave_mem(b_bus_addr); end
      else if (b_cnt >= 0) b_cnt++;
    end
  end
  assign bus_rdata   = (a_cnt == 1) ? a_val : 32'hBAD0_BAD0;
  assign b_bus_rdata = (b_cnt == 3) ? b_val : 32'hBAD0_BAD0;

  // Scoreboard for instance a
  typedef struct { logic wr; logic [31:0] rdata; int lat; } rsp_t;
  typedef struct { logic wr; logic [9:0] addr; logic [31:0] wdata; } bus_t;
  rsp_t rq[$];
  bus_t bq[$];
  int strobe_cyc = 0, first_cyc = 0;
  logic prev_rv = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_rv = 1'b0;
    end else begin
      if (bus_wr_en || bus_rd_en) begin
        bus_t eb;
        strobe_cyc = cyc;
        check("strobe_excl", {31'd0, bus_wr_en & bus_rd_en}, 32'd0);
        check("ready_busy", {31'd0, cmd_ready}, 32'd0);
        if (bq.size() == 0) flag("bus_unexpected_strobe");
        else begin
          eb = bq.pop_front();
          check("bus_wr_en", {31'd0, bus_wr_en}, {31'd0, eb.wr});
          check("bus_addr", {22'd0, bus_addr}, {22'd0, eb.addr});
          check("bus_wdata", bus_wdata, eb.wdata);
        end
      end
      if (rsp_valid && !prev_rv) first_cyc = cyc;
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        rsp_t er;
        check("idle_bus", {bus_wr_en, bus_rd_en, bus_addr, bus_wdata[19:0]}, 32'd0);
        if (rq.size() == 0) flag("rsp_unexpected");
        else begin
          er = rq.pop_front();
          check("rsp_write", {31'd0, rsp_write}, {31'd0, er.wr});
          check("rsp_rdata", rsp_rdata, er.rdata);
          check("rsp_latency", first_cyc - strobe_cyc, er.lat);
        end
      end
    end
  end

  // Event counters for strobes and interrupt pulses
  int a_irqs = 0, b_irqs = 0, b_strobes = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ovf_irq) a_irqs++;
      if (b_ovf_irq) b_irqs++;
      if (b_bus_wr_en || b_bus_rd_en) begin
        b_strobes++;
        check("b_bus_addr", {22'd0, b_bus_addr}, 32'h0000_000C);
        check("b_bus_wdata", b_bus_wdata, 32'd0);
      end
    end
  end

  task automatic send(input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input int lat);
    int n;
    rq.push_back('{wr: wr, rdata: exp_rd, lat: lat});
    bq.push_back('{wr: wr, addr: addr, wdata: wr ? wd : 32'd0});
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 50) begin tick; n++; end
    if (!cmd_ready) flag("accept_timeout");
    tick;
    cmd_valid = 1'b0;
    check("ready_after_accept", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (rq.size() != 0 && n < 50) begin tick; n++; end
    if (rq.size() != 0) begin flag("rsp_timeout"); rq.delete(); end
    if (bq.size() != 0) begin flag("strobe_missing"); bq.delete(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
    b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = '0; b_cmd_wdata = '0; b_rsp_ready = 0;
    bus_overflow = 0;
    repeat (3) tick;
    check("rst_ctrl", {26'd0, cmd_ready, rsp_valid, rsp_write, bus_wr_en, bus_rd_en, ovf_irq}, 32'd0);
    check("rst_addr", {22'd0, bus_addr}, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_events", {24'd0, ovf_events}, 32'd0);
    rst = 1'b0;
    tick;
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // write, then read at RD_LAT=1
    rsp_ready = 1'b1;
    send(1'b1, 10'h000, 32'h0000_0001, 32'd0, 1);
    wait_idle;
    send(1'b0, 10'h004, 32'hFFFF_FFFF, 32'h0000_0003, 2);
    wait_idle;

    // backpressure on a read, with a second command offered meanwhile
    rsp_ready = 1'b0;
    send(1'b0, 10'h008, 32'd0, 32'd0, 2);
    k = 0;
    while (!rsp_valid && k < 20) begin tick; k++; end
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rq.push_back('{wr: 1'b1, rdata: 32'd0, lat: 1});
    bq.push_back('{wr: 1'b1, addr: 10'h010, wdata: 32'hA5A5_A5A5});
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h010; cmd_wdata = 32'hA5A5_A5A5;
    repeat (5) begin
      tick;
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_rdata", rsp_rdata, 32'd0);
      check("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick;
    check("ready_after_hs", {31'd0, cmd_ready}, 32'd1);
    tick;
    cmd_valid = 1'b0;
    check("bp_second_accept", {31'd0, cmd_ready}, 32'd0);
    wait_idle;

    // RD_LAT=3 read on instance b
    b_rsp_ready = 1'b1;
    b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 10'h00C;
    tick;
    b_cmd_valid = 1'b0;
    k = 0;
    while (!b_rsp_valid && k < 20) begin tick; k++; end
    check("b_latency", k, 32'd4);
    check("b_rdata", b_rsp_rdata, 32'hDEAD_BEEF);
    check("b_rsp_write", {31'd0, b_rsp_write}, 32'd0);
    check("b_strobes", b_strobes, 32'd1);
    tick;
    check("b_rsp_done", {31'd0, b_rsp_valid}, 32'd0);

    // overflow: high 4, low 2, high again
    bus_overflow = 1'b1; repeat (4) tick;
    bus_overflow = 1'b0; repeat (2) tick;
    bus_overflow = 1'b1; repeat (3) tick;
    check("ovf_irqs_2", a_irqs, 32'd2);
    check("ovf_events_2", {24'd0, ovf_events}, 32'd2);
    repeat (3) begin
      bus_overflow = 1'b0; repeat (2) tick;
      bus_overflow = 1'b1; repeat (2) tick;
    end
    tick;
    check("ovf_irqs_5", a_irqs, 32'd5);
    check("ovf_events_5", {24'd0, ovf_events}, 32'd5);
    check("b_irqs_5", b_irqs, 32'd5);
    check("b_events_sat", {30'd0, b_ovf_events}, 32'd3);
    bus_overflow = 1'b0;

    // reset during the WAIT cycle of a read
    bq.push_back('{wr: 1'b0, addr: 10'h010, wdata: 32'd0});
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010;
    tick;
    cmd_valid = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ctrl", {27'd0, cmd_ready, rsp_valid, bus_wr_en, bus_rd_en, ovf_irq}, 32'd0);
    check("mid_rst_addr", {22'd0, bus_addr}, 32'd0);
    check("mid_rst_events", {24'd0, ovf_events}, 32'd0);
    repeat (2) tick;
    rst = 1'b0;
    tick;
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (4) tick;
    check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    send(1'b0, 10'h010, 32'd0, 32'h1234_5678, 2);
    wait_idle;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Register-bus initiator: accepts single register-access commands over a valid/ready interface and drives the peripheral register bus (wr_en/rd_en/addr/wdata/rdata).
- Returns one response per command over a valid/ready interface.
- Sits between a controller (CPU shim or sequencer) and register-mapped peripherals such as counter_top.
- Also converts the peripheral overflow level into an interrupt pulse and a saturating event count.

Parameters:
ADDR_W, 10, register address width
DATA_W, 32, register data width
RD_LAT, 1, cycles from the bus_rd_en strobe cycle to the bus_rdata capture edge (legal range 1-7)
EVT_W, 8, overflow event counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target register address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when high together with rsp_valid
rsp_write  out  1  echo of the command type
rsp_rdata  out  DATA_W  read data; 0 for writes
bus_wr_en  out  1  write strobe, one cycle per write
bus_rd_en  out  1  read strobe, one cycle per read
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_rdata  in  DATA_W  peripheral read data
bus_overflow  in  1  peripheral overflow level (synchronous to clk)
ovf_irq  out  1  one-cycle pulse on each 0->1 edge of bus_overflow
ovf_events  out  EVT_W  count of overflow edges, saturating

Behaviour:
- Reset (async, active-high): FSM=IDLE. Every output is 0, except cmd_ready, which is 1 after reset deasserts. Internal ovf_prev=0.
- Reset mid-transaction aborts it: no strobe completes, no response is issued, and the latched command is discarded.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On a cmd_valid&cmd_ready edge: latch write, addr and wdata, then go to ACCESS.
  - No other state asserts cmd_ready, so there is exactly one outstanding command.
- ACCESS (exactly 1 cycle):
  - bus_addr and bus_wdata are driven from the latched command.
  - Write: bus_wr_en=1, bus_wdata=latched data, next state RESP.
  - Read: bus_rd_en=1, bus_wdata=0, next state WAIT with the latency counter loaded to RD_LAT.
- WAIT (reads only):
  - Lasts RD_LAT cycles; bus_addr holds the latched address and both strobes are 0.
  - bus_rdata is captured into rsp_rdata on the edge ending the last WAIT cycle, then next state is RESP.
- RESP:
  - rsp_valid=1; rsp_write and rsp_rdata are stable until the rsp_valid&rsp_ready edge, then next state is IDLE.
  - rsp_ready may be held high in advance; RESP then lasts 1 cycle.
- Bus outputs outside ACCESS/WAIT: strobes 0, bus_addr=0, bus_wdata=0 (never X). bus_wr_en and bus_rd_en are never high together.
- Latency (accept edge = E, rsp_ready held high):
  - Write: strobe in the cycle after E; rsp_valid in the cycle after the strobe.
  - Read: strobe in the cycle after E; rsp_valid RD_LAT+1 cycles after the strobe cycle.
  - The next command is accepted no earlier than the cycle after the response handshake.
- Overflow:
  - ovf_prev is registered each cycle.
  - ovf_irq = bus_overflow & ~ovf_prev, registered, so the pulse appears 1 cycle after the rising level.
  - A level held high produces a single pulse; the level dropping and rising again produces a new pulse.
  - ovf_events increments on each pulse and saturates at 2^EVT_W-1 (no wrap). It is cleared only by rst.
- Command and overflow logic are independent; an overflow edge during any FSM state is counted.

Test Plan:
- Write: after reset, cmd write addr=0x000 wdata=0x00000001 with rsp_ready=1 -> cmd_ready=1 in the first cycle after reset; exactly one bus_wr_en pulse with bus_addr=0x000 and bus_wdata=0x1; rsp_valid 1 cycle later with rsp_write=1 and rsp_rdata=0; cmd_ready=0 from the accept edge until after the handshake.
- Read at default latency: slave model returns 0x00000003 one cycle after the strobe; cmd read addr=0x004 (RD_LAT=1) -> single bus_rd_en pulse, rsp_rdata=0x00000003, rsp_valid 2 cycles after the strobe cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles during a read of 0x008 returning 0 -> rsp_valid stays high with rsp_rdata=0 stable; cmd_ready stays 0; a cmd_valid offered meanwhile is not accepted until the cycle after the handshake.
- Longer read latency: RD_LAT=3 with the slave returning 0xDEADBEEF 3 cycles after the strobe -> rsp_rdata=0xDEADBEEF; no strobes during the 3 WAIT cycles.
- Overflow edges: bus_overflow high for 4 cycles, low 2 cycles, high again -> exactly two ovf_irq pulses, ovf_events=2. With EVT_W=2, 5 edges -> ovf_events saturates at 3.
- Reset mid-read: assert rst during WAIT -> all outputs 0 immediately, no rsp_valid ever appears, cmd_ready=1 the first cycle after release, and a following read completes normally.
